// File: rtl/pc_sequencer.sv
// Fetch-side program counter generator: sequential increment, stall hold,
// redirect with a fixed bubble count, halt, and a count of accepted fetches.
module pc_sequencer #(
    parameter int              ISIZE            = 16,
    parameter logic [ISIZE-1:0] RESET_PC        = '0,
    parameter int              PC_STEP          = 1,
    parameter int              REDIRECT_BUBBLES = 1,
    parameter int              CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [ISIZE-1:0] redirect_pc,
    input  logic             halt,
    output logic [ISIZE-1:0] PC_out,
    output logic             pc_valid,
    output logic [CNT_W-1:0] fetch_count,
    output logic             busy_flush
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALTED} state_t;

    localparam logic [2:0]       BUBBLE_LOAD = 3'(REDIRECT_BUBBLES - 1);
    localparam logic [ISIZE-1:0] STEP        = ISIZE'(PC_STEP);

    state_t           state_reg, state_next;
    logic [2:0]       bubble_reg, bubble_next;
    logic [ISIZE-1:0] pc_next;
    logic             valid_next;
    logic [CNT_W-1:0] count_next;
    logic             accept;

    assign busy_flush = (state_reg == FLUSH);

    always_comb begin
        state_next  = state_reg;
        bubble_next = bubble_reg;
        pc_next     = PC_out;
        valid_next  = pc_valid;
        // The accepted fetch is counted even when a redirect or halt lands on the same edge.
        accept      = pc_valid & ~stall;
        count_next  = fetch_count + {{(CNT_W-1){1'b0}}, accept};

        if (redirect_valid) begin
            state_next  = FLUSH;
            pc_next     = redirect_pc;
            valid_next  = 1'b0;
            bubble_next = BUBBLE_LOAD;
        end else if (halt && state_reg != HALTED) begin
            state_next = HALTED;
            valid_next = 1'b0;
        end else begin
            case (state_reg)
                BOOT: begin
                    state_next = RUN;
                    valid_next = 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        pc_next = PC_out + STEP;
                    end
                end
                FLUSH: begin
                    // Target is held; stall has no effect while bubbles drain.
                    if (bubble_reg == 3'd0) begin
                        state_next = RUN;
                        valid_next = 1'b1;
                    end else begin
                        bubble_next = bubble_reg - 3'd1;
                    end
                end
                HALTED: begin
                    valid_next = 1'b0;
                end
                default: begin
                    state_next = BOOT;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= BOOT;
            bubble_reg  <= 3'd0;
            PC_out      <= RESET_PC;
            pc_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            state_reg   <= state_next;
            bubble_reg  <= bubble_next;
            PC_out      <= pc_next;
            pc_valid    <= valid_next;
            fetch_count <= count_next;
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side PC generator. Produces the program counter that feeds the fetch stage and the downstream PC delay registers.
- Provides sequential increment, stall hold, redirect from the execute stage with a configurable bubble count, a halt state, and a count of accepted fetches.
- Sits at the head of the pipeline: its PC_out is the PC_in of the first PC delay stage.

Parameters:
- ISIZE, 16, PC width in bits; must equal the global `ISIZE.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, increment per accepted fetch. Word-addressed, so 1.
- REDIRECT_BUBBLES, 1, invalid cycles inserted after a redirect. Legal range 1..7.
- CNT_W, 16, width of fetch_count.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- stall, input, 1, downstream not ready; hold PC.
- redirect_valid, input, 1, branch/jump resolved taken; load redirect_pc.
- redirect_pc, input, ISIZE, redirect target.
- halt, input, 1, stop fetching (HALT instruction decoded).
- PC_out, output reg, ISIZE, current fetch PC.
- pc_valid, output reg, 1, PC_out is a real fetch this cycle.
- fetch_count, output reg, CNT_W, number of accepted fetches.
- busy_flush, output, 1, high while in FLUSH state.

Behaviour:
- All state is updated on posedge clk. The design has one clock and a synchronous active-high reset (rst).
- Reset values: PC_out=RESET_PC, pc_valid=0, fetch_count=0, state=BOOT, bubble counter=0.
- Reset has priority over everything, including mid-flush and halted states.
- States: BOOT, RUN, FLUSH, HALTED.
- Priority within a cycle: rst > redirect_valid > halt > stall > increment.
- Accepted fetch: any cycle with pc_valid=1 and stall=0. Each accepted fetch increments fetch_count by 1, wrapping modulo 2^CNT_W. fetch_count counts the accepted fetch even when the same edge applies a redirect or halt.
- BOOT:
  - With no redirect/halt, go to RUN next cycle with pc_valid=1 and PC_out=RESET_PC. The first valid PC appears one cycle after rst deasserts.
  - redirect or halt in BOOT is handled as it would be in RUN.
- RUN:
  - stall=1: PC_out and pc_valid held; no count.
  - stall=0: PC_out <= PC_out+PC_STEP. The addition wraps modulo 2^ISIZE (e.g. 0xFFFF+1 -> 0x0000 at ISIZE=16).
- redirect_valid=1 (any state except reset):
  - Next cycle: PC_out=redirect_pc, pc_valid=0, state=FLUSH, bubble counter loaded with REDIRECT_BUBBLES-1.
  - Redirect overrides stall and halt in the same cycle.
  - redirect_pc is used unmodified; there is no alignment masking.
- FLUSH:
  - pc_valid=0 and PC_out held, regardless of stall.
  - Bubble counter decrements each cycle. When it reaches 0, the next cycle is RUN with pc_valid=1 at the held target.
  - Total invalid cycles after the redirect edge equal REDIRECT_BUBBLES.
  - A new redirect during FLUSH reloads the target and restarts the bubble count.
  - halt during FLUSH goes to HALTED (target retained).
- halt=1 in RUN:
  - Next cycle: state=HALTED, pc_valid=0, PC_out held at the current value (no increment).
- HALTED:
  - pc_valid=0; PC_out and fetch_count frozen. stall and halt are ignored.
  - Exits only via redirect (to FLUSH) or rst.
- busy_flush is combinational (state==FLUSH).

Test Plan:
- Reset then run: rst high 2 cycles, release, stall=0 -> cycle+1 PC_out=0 pc_valid=1; next 4 cycles PC_out=1,2,3,4; fetch_count=4 after the fourth increment.
- Stall hold: in RUN at PC=5, stall high 3 cycles -> PC_out stays 5, pc_valid=1, fetch_count unchanged; stall low -> PC_out=6, count+1.
- Redirect with bubbles: REDIRECT_BUBBLES=2, redirect_valid with redirect_pc=0x0040 while stall=1 -> pc_valid=0 for 2 cycles with PC_out=0x0040 and busy_flush=1; third cycle pc_valid=1 PC=0x0040, then 0x0041.
- Back-to-back redirect: redirect to 0x0100, next cycle redirect to 0x0200 -> target becomes 0x0200, bubble count restarts; 0x0100 never appears with pc_valid=1.
- Halt and resume: halt at PC=0x0010 -> HALTED, pc_valid=0, PC held at 0x0010 through 5 stall/halt toggles; redirect to 0x0020 -> FLUSH then valid PC 0x0020. Same-cycle halt+redirect -> redirect wins.
- Wrap and reset mid-flush: RESET_PC=0xFFFE -> PCs 0xFFFE, 0xFFFF, 0x0000; assert rst during FLUSH -> next cycle PC_out=0xFFFE, pc_valid=0, fetch_count=0, busy_flush=0.
